// File: rtl/mdu_pkg.sv
// mdu_pkg: shared definitions for the multiply/divide unit.
//   mdu_op_e    - operation encodings on the 3-bit mdu_op input
//   mdu_state_e - iteration FSM states
//   mag32       - magnitude of a 32-bit operand, signed or unsigned view
package mdu_pkg;

  typedef enum logic [2:0] {
    OP_NOP   = 3'b000,
    OP_MULT  = 3'b001,
    OP_MULTU = 3'b010,
    OP_DIV   = 3'b011,
    OP_DIVU  = 3'b100,
    OP_MTHI  = 3'b101,
    OP_MTLO  = 3'b110,
    OP_RSVD  = 3'b111
  } mdu_op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_FIX  = 2'd2
  } mdu_state_e;

  localparam int unsigned STEPS = 32;

  // 32'h8000_0000 negates to itself, which read unsigned is the correct 2^31.
  function automatic logic [31:0] mag32(input logic [31:0] v, input logic is_signed);
    return (is_signed && v[31]) ? (~v + 32'd1) : v;
  endfunction

endpackage

// File: rtl/mdu_step.sv
// mdu_step: one combinational radix-2 iteration on unsigned magnitudes.
//   i_is_div  0: shift-add multiply step, 1: restoring shift-subtract divide step
//   i_hi/i_lo working accumulator pair
//     multiply: i_hi = partial product, i_lo = remaining multiplier bits
//     divide:   i_hi = partial remainder, i_lo = dividend bits / quotient bits
//   i_opnd    multiplicand (multiply) or divisor (divide)
//   o_hi/o_lo accumulator pair after the step
module mdu_step
  import mdu_pkg::*;
(
  input  logic        i_is_div,
  input  logic [31:0] i_hi,
  input  logic [31:0] i_lo,
  input  logic [31:0] i_opnd,
  output logic [31:0] o_hi,
  output logic [31:0] o_lo
);

  logic [32:0] w_sum;
  logic [32:0] w_shifted;
  logic [32:0] w_diff;

  // Multiply: add the multiplicand when the multiplier LSB is set, then shift
  // the 65-bit {carry,hi,lo} right by one.
  assign w_sum = {1'b0, i_hi} + (i_lo[0] ? {1'b0, i_opnd} : 33'd0);

  // Divide: shift the next dividend bit into the remainder and trial-subtract.
  // The remainder stays below the divisor, so 33 bits always suffice.
  assign w_shifted = {i_hi, i_lo[31]};
  assign w_diff    = w_shifted - {1'b0, i_opnd};

  always_comb begin
    o_hi = 32'd0;
    o_lo = 32'd0;
    if (i_is_div) begin
      o_hi = w_diff[32] ? w_shifted[31:0] : w_diff[31:0];
      o_lo = {i_lo[30:0], ~w_diff[32]};
    end else begin
      o_hi = w_sum[32:1];
      o_lo = {w_sum[0], i_lo[31:1]};
    end
  end

endmodule

// File: rtl/mdu.sv
// mdu: iterative 32-bit multiply/divide unit with HI/LO registers.
//   clk, reset     clock, synchronous active-high reset
//   start, mdu_op  request and operation (accepted only while idle)
//   a, b           operands rs / rt
//   cancel         abort an in-flight multiply/divide
//   busy           high while an iterative op is in flight
//   done           one-cycle pulse after hi/lo take a new result
//   hi, lo         architectural HI/LO registers
//   o_dbg_state    current FSM state
// Handshake: a request is taken on a rising edge where start=1, busy=0,
// cancel=0 and reset=0; there is no backpressure beyond busy. done is valid
// for exactly one cycle and needs no acknowledge.
module mdu
  import mdu_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  mdu_op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        cancel,
  output logic        busy,
  output logic        done,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output mdu_state_e  o_dbg_state
);

  mdu_state_e  r_state;
  mdu_state_e  w_next;
  mdu_op_e     r_op;
  logic [4:0]  r_cnt;
  logic [31:0] r_a;
  logic [31:0] r_b;
  logic [31:0] r_opnd;
  logic [31:0] r_acc_hi;
  logic [31:0] r_acc_lo;
  logic [31:0] r_hi;
  logic [31:0] r_lo;
  logic        r_done;

  mdu_op_e     w_op;
  logic        w_accept;
  logic        w_iter_op;
  logic        w_op_div;
  logic        w_op_signed;
  logic        w_r_div;
  logic        w_r_signed;
  logic [31:0] w_step_hi;
  logic [31:0] w_step_lo;
  logic [63:0] w_prod;
  logic [31:0] w_fix_hi;
  logic [31:0] w_fix_lo;

  assign w_op        = mdu_op_e'(mdu_op);
  assign w_accept    = start && !cancel && (r_state == ST_IDLE);
  assign w_iter_op   = (w_op == OP_MULT) || (w_op == OP_MULTU) ||
                       (w_op == OP_DIV)  || (w_op == OP_DIVU);
  assign w_op_div    = (w_op == OP_DIV)  || (w_op == OP_DIVU);
  assign w_op_signed = (w_op == OP_MULT) || (w_op == OP_DIV);
  assign w_r_div     = (r_op == OP_DIV)  || (r_op == OP_DIVU);
  assign w_r_signed  = (r_op == OP_MULT) || (r_op == OP_DIV);

  mdu_step u_step (
    .i_is_div (w_r_div),
    .i_hi     (r_acc_hi),
    .i_lo     (r_acc_lo),
    .i_opnd   (r_opnd),
    .o_hi     (w_step_hi),
    .o_lo     (w_step_lo)
  );

  // Sign correction applied on the way into HI/LO.
  assign w_prod = {r_acc_hi, r_acc_lo};

  always_comb begin
    w_fix_hi = r_acc_hi;
    w_fix_lo = r_acc_lo;
    if (!w_r_div) begin
      if (w_r_signed && (r_a[31] ^ r_b[31])) begin
        {w_fix_hi, w_fix_lo} = ~w_prod + 64'd1;
      end else begin
        {w_fix_hi, w_fix_lo} = w_prod;
      end
    end else if (r_b == 32'd0) begin
      w_fix_hi = r_a;
      w_fix_lo = 32'hFFFF_FFFF;
    end else begin
      if (w_r_signed && (r_a[31] ^ r_b[31])) w_fix_lo = ~r_acc_lo + 32'd1;
      if (w_r_signed && r_a[31])             w_fix_hi = ~r_acc_hi + 32'd1;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE: if (w_accept && w_iter_op) w_next = ST_CALC;
      ST_CALC: begin
        if (cancel)                  w_next = ST_IDLE;
        else if (r_cnt == 5'd31)     w_next = ST_FIX;
      end
      ST_FIX:  w_next = ST_IDLE;
      default: w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= ST_IDLE;
      r_op     <= OP_NOP;
      r_cnt    <= 5'd0;
      r_a      <= 32'd0;
      r_b      <= 32'd0;
      r_opnd   <= 32'd0;
      r_acc_hi <= 32'd0;
      r_acc_lo <= 32'd0;
      r_hi     <= 32'd0;
      r_lo     <= 32'd0;
      r_done   <= 1'b0;
    end else begin
      r_state <= w_next;
      r_done  <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            if (w_iter_op) begin
              r_op     <= w_op;
              r_a      <= a;
              r_b      <= b;
              r_cnt    <= 5'd0;
              r_acc_hi <= 32'd0;
              // Divide iterates over the dividend, multiply over the multiplier.
              r_acc_lo <= w_op_div ? mag32(a, w_op_signed) : mag32(b, w_op_signed);
              r_opnd   <= w_op_div ? mag32(b, w_op_signed) : mag32(a, w_op_signed);
            end else if (w_op == OP_MTHI) begin
              r_hi <= a;
            end else if (w_op == OP_MTLO) begin
              r_lo <= a;
            end
          end
        end
        ST_CALC: begin
          if (!cancel) begin
            r_acc_hi <= w_step_hi;
            r_acc_lo <= w_step_lo;
            r_cnt    <= r_cnt + 5'd1;
          end
        end
        ST_FIX: begin
          if (!cancel) begin
            r_hi   <= w_fix_hi;
            r_lo   <= w_fix_lo;
            r_done <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign busy        = (r_state != ST_IDLE);
  assign done        = r_done;
  assign hi          = r_hi;
  assign lo          = r_lo;
  assign o_dbg_state = r_state;

endmodule

// File: doc/mdu.md
MDU -- requirements
Module: mdu

Interface
REQ-001 No parameters; datapath width fixed at 32 bits.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 start  input  1  request; accepted only when busy=0.
REQ-005 mdu_op  input  3  operation: 000 NOP, 001 MULT, 010 MULTU, 011 DIV, 100 DIVU, 101 MTHI, 110 MTLO, 111 reserved.
REQ-006 a  input  32  operand rs (dividend/multiplicand; MTHI/MTLO source).
REQ-007 b  input  32  operand rt (divisor/multiplier).
REQ-008 cancel  input  1  abort in-flight MULT/DIV (pipeline flush).
REQ-009 busy  output  1  high while an iterative op is in flight; decode stalls mfhi/mflo/mult/div on it.
REQ-010 done  output  1  one-cycle pulse; hi/lo hold a new MULT/DIV result.
REQ-011 hi  output  32  HI register; feeds mfhi writeback.
REQ-012 lo  output  32  LO register; feeds mflo writeback.

Function
REQ-013 FSM states: IDLE, CALC, FIX; busy = (state != IDLE).
REQ-014 IDLE and start and op in {MULT,MULTU,DIV,DIVU} at edge E0: latch operands and op, clear 5-bit counter, go to CALC.
REQ-015 CALC: one radix-2 step per cycle; 32 cycles (E1..E32); E32 moves to FIX.
REQ-016 FIX: apply sign correction; edge E33 writes hi/lo, returns to IDLE, sets done for exactly the following cycle.
REQ-017 Latency: busy high for 33 cycles after E0; new hi/lo visible after E33; back-to-back start accepted at E34 (busy=0 in that cycle).
REQ-018 MULT/MULTU: {hi,lo} = full 64-bit product; signed version multiplies magnitudes, negates the product when a[31]^b[31].
REQ-019 DIVU: restoring division; lo = quotient, hi = remainder.
REQ-020 DIV: divide magnitudes; quotient negated when a[31]^b[31]; remainder takes sign of a; truncation toward zero.
REQ-021 Divide by zero (DIV or DIVU): lo = 32'hFFFF_FFFF, hi = a; same 33-cycle timing.
REQ-022 DIV 32'h8000_0000 / 32'hFFFF_FFFF: lo = 32'h8000_0000, hi = 0, no trap.
REQ-023 MTHI/MTLO with start in IDLE: hi (resp. lo) <= a at that edge; busy stays 0; no done.
REQ-024 start while busy (any op): ignored; no effect on state, hi or lo.
REQ-025 NOP, reserved op, or start=0: no effect.
REQ-026 cancel in CALC or FIX: next state IDLE, hi/lo unchanged, no done; cancel in IDLE: no effect; cancel with start on the same edge: cancel wins, start dropped.
REQ-027 hi/lo change only per REQ-016, REQ-023 or reset.

Reset
REQ-028 reset at an edge: state IDLE, counter 0, hi = 0, lo = 0, busy = 0, done = 0; overrides start and cancel.
REQ-029 reset mid-operation discards the in-flight op; no done follows.

Structure
REQ-030 Shared package mdu_pkg holds the mdu_op enum encodings (REQ-005) and the FSM state enum; decode imports the same package.
REQ-031 One sub-module mdu_step: combinational single-iteration shift-add / shift-subtract, selected by a mul/div flag; mdu owns all registers and the FSM.

Verification
REQ-032 MULT a=32'hFFFF_FFFD (-3), b=5 -> busy 33 cycles, done pulse, hi=32'hFFFF_FFFF, lo=32'hFFFF_FFF1.
REQ-033 MULTU a=b=32'hFFFF_FFFF -> hi=32'hFFFF_FFFE, lo=32'h0000_0001.
REQ-034 DIV a=-7, b=2 -> lo=32'hFFFF_FFFD, hi=32'hFFFF_FFFF; DIVU a=7, b=0 -> lo=32'hFFFF_FFFF, hi=7; DIV 32'h8000_0000 / -1 -> lo=32'h8000_0000, hi=0.
REQ-035 DIVU 100/7 started; start MULT at cycle 5 -> ignored, result lo=14, hi=2 after E33.
REQ-036 MTLO a=32'h1234_5678 in IDLE -> lo updates next edge, busy stays 0; then MULT 3*4 with cancel at cycle 10 -> busy drops next edge, lo stays 32'h1234_5678, no done.
REQ-037 DIV in flight, reset at cycle 10 -> busy=0, done=0, hi=lo=0 after that edge; no later done.
